// File: rtl/draw_overlay_box_if.sv
// ============================================================================
// Module   : vga_if
// Purpose  : VGA timing/pixel bundle passed between drawing-chain stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave   (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master  (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_overlay_box.sv
// ============================================================================
// Module   : draw_overlay_box
// Purpose  : Animated bordered box overlay: slides open top-down, then blinks
//            its border. One-cycle registered pass-through of the VGA stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module draw_overlay_box #(
  parameter int          X_START      = 400,
  parameter int          Y_START      = 200,
  parameter int          BOX_W        = 200,
  parameter int          BOX_H        = 100,
  parameter logic [2:0]  SHOW_STATE   = 3'b100,
  parameter logic [11:0] FILL_RGB     = 12'hFF0,
  parameter logic [11:0] BORDER_RGB   = 12'hF00,
  parameter int          BORDER_W     = 4,
  parameter int          REVEAL_STEP  = 4,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   game_state,
  output logic         over_on,
  vga_if.vga_in        vga_in,
  vga_if.vga_out       vga_out
);

  localparam int c_RH_W = (BOX_H > 1) ? $clog2(BOX_H + 1) : 1;
  localparam int c_BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Step is clamped to the box height so the widened sum can never wrap.
  localparam logic [c_RH_W:0]   c_STEP  = (c_RH_W + 1)'((REVEAL_STEP > BOX_H) ? BOX_H : REVEAL_STEP);
  localparam logic [c_RH_W:0]   c_BOX_H = (c_RH_W + 1)'(BOX_H);
  localparam logic [c_BC_W-1:0] c_BLINK_LAST = c_BC_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  localparam logic [11:0] c_X_LO = 12'(X_START);
  localparam logic [11:0] c_X_HI = 12'(X_START + BOX_W);
  localparam logic [11:0] c_X_BL = 12'(X_START + BORDER_W);
  localparam logic [11:0] c_X_BR = 12'(X_START + BOX_W - BORDER_W);
  localparam logic [11:0] c_Y_LO = 12'(Y_START);
  localparam logic [11:0] c_Y_BT = 12'(Y_START + BORDER_W);
  localparam logic [11:0] c_Y_BB = 12'(Y_START + BOX_H - BORDER_W);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_REVEAL = 2'd1;
  localparam logic [1:0] c_SHOWN  = 2'd2;

  logic [1:0]        r_state;
  logic [c_RH_W-1:0] r_reveal_h;
  logic [c_BC_W-1:0] r_blink_cnt;
  logic              r_border_vis;
  logic              r_vblnk_d;

  logic              w_show;
  logic              w_tick;
  logic [c_RH_W:0]   w_sum;
  logic [c_RH_W-1:0] w_reveal_next;
  logic [11:0]       w_h;
  logic [11:0]       w_v;
  logic [11:0]       w_y_hi;
  logic              w_in_box;
  logic              w_border;
  logic              w_draw;
  logic [11:0]       w_rgb;

  assign w_show        = (game_state == SHOW_STATE);
  assign w_tick        = vga_in.vblnk & ~r_vblnk_d;
  assign w_sum         = {1'b0, r_reveal_h} + c_STEP;
  assign w_reveal_next = (w_sum >= c_BOX_H) ? c_BOX_H[c_RH_W-1:0] : w_sum[c_RH_W-1:0];

  assign w_h    = {1'b0, vga_in.hcount};
  assign w_v    = {1'b0, vga_in.vcount};
  assign w_y_hi = c_Y_LO + 12'(r_reveal_h);

  assign w_in_box = (w_h >= c_X_LO) && (w_h < c_X_HI) && (w_v >= c_Y_LO) && (w_v < w_y_hi);
  // Border is measured against the full box, so the bottom edge only shows once fully open.
  assign w_border = (w_h < c_X_BL) || (w_h >= c_X_BR) || (w_v < c_Y_BT) || (w_v >= c_Y_BB);
  assign w_draw   = (r_state != c_IDLE) && w_in_box && !vga_in.hblnk && !vga_in.vblnk;
  assign w_rgb    = !w_draw                  ? vga_in.rgb :
                    (w_border && r_border_vis) ? BORDER_RGB : FILL_RGB;

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
      over_on        <= 1'b0;
      r_state        <= c_IDLE;
      r_reveal_h     <= '0;
      r_blink_cnt    <= '0;
      r_border_vis   <= 1'b1;
      r_vblnk_d      <= 1'b0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.rgb    <= w_rgb;
      over_on        <= w_draw;
      r_vblnk_d      <= vga_in.vblnk;

      // Leaving the show state wins over any frame tick in the same cycle.
      if (!w_show) begin
        r_state    <= c_IDLE;
        r_reveal_h <= '0;
      end else begin
        case (r_state)
          c_IDLE: begin
            r_state    <= c_REVEAL;
            r_reveal_h <= '0;
          end
          c_REVEAL: begin
            if (w_tick) begin
              r_reveal_h <= w_reveal_next;
              if (w_reveal_next == c_BOX_H[c_RH_W-1:0]) begin
                r_state      <= c_SHOWN;
                r_border_vis <= 1'b1;
                r_blink_cnt  <= '0;
              end
            end
          end
          c_SHOWN: begin
            if (w_tick && (BLINK_FRAMES > 0)) begin
              if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt  <= '0;
                r_border_vis <= ~r_border_vis;
              end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
              end
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
